// File: rtl/dpram_be_init.sv
`default_nettype none
// ============================================================================
// dpram_be_init : true dual-port byte-enable RAM with reset/on-demand init sweep
// Revision 1.0
// ============================================================================
module dpram_be_init #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 12,
  parameter int                RD_LAT    = 1,
  parameter int                COLL_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_req,
  output logic                ready,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic a_acc, b_acc, a_wr, b_wr;
  assign a_acc = a_en && (state_q == ST_READY);
  assign b_acc = b_en && (state_q == ST_READY);
  assign a_wr  = a_acc && a_we;
  assign b_wr  = b_acc && b_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_READY;
      end
      ST_READY: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

  // Port A is applied last so it owns any lane both ports enable.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b_wr && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
        if (a_wr && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      end
    end
  end

  logic [DATA_W-1:0] a_old, b_old, a_new, b_new, a_rd, b_rd;

  always_comb begin
    a_old = mem[a_addr];
    b_old = mem[b_addr];
    a_new = a_old;
    b_new = b_old;
    for (int i = 0; i < NB; i++) begin
      if (b_wr && b_be[i] && (b_addr == a_addr)) a_new[i*8 +: 8] = b_wdata[i*8 +: 8];
      if (a_wr && a_be[i])                       a_new[i*8 +: 8] = a_wdata[i*8 +: 8];
      if (b_wr && b_be[i])                       b_new[i*8 +: 8] = b_wdata[i*8 +: 8];
      if (a_wr && a_be[i] && (a_addr == b_addr)) b_new[i*8 +: 8] = a_wdata[i*8 +: 8];
    end
    a_rd = (COLL_MODE == 1) ? a_old : a_new;
    b_rd = (COLL_MODE == 1) ? b_old : b_new;
  end

  logic [DATA_W-1:0] a_s1_data_q, a_s1_data_d, b_s1_data_q, b_s1_data_d;
  logic              a_s1_valid_q, a_s1_valid_d, b_s1_valid_q, b_s1_valid_d;

  always_comb begin
    a_s1_valid_d = a_acc;
    b_s1_valid_d = b_acc;
    a_s1_data_d  = a_acc ? a_rd : a_s1_data_q;
    b_s1_data_d  = b_acc ? b_rd : b_s1_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1_data_q  <= '0;
      b_s1_data_q  <= '0;
      a_s1_valid_q <= 1'b0;
      b_s1_valid_q <= 1'b0;
    end else begin
      a_s1_data_q  <= a_s1_data_d;
      b_s1_data_q  <= b_s1_data_d;
      a_s1_valid_q <= a_s1_valid_d;
      b_s1_valid_q <= b_s1_valid_d;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      // Stage 1 already holds its last read, so a plain copy keeps rdata stable.
      logic [DATA_W-1:0] a_s2_data_q, a_s2_data_d, b_s2_data_q, b_s2_data_d;
      logic              a_s2_valid_q, a_s2_valid_d, b_s2_valid_q, b_s2_valid_d;

      always_comb begin
        a_s2_data_d  = a_s1_data_q;
        b_s2_data_d  = b_s1_data_q;
        a_s2_valid_d = a_s1_valid_q;
        b_s2_valid_d = b_s1_valid_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_s2_data_q  <= '0;
          b_s2_data_q  <= '0;
          a_s2_valid_q <= 1'b0;
          b_s2_valid_q <= 1'b0;
        end else begin
          a_s2_data_q  <= a_s2_data_d;
          b_s2_data_q  <= b_s2_data_d;
          a_s2_valid_q <= a_s2_valid_d;
          b_s2_valid_q <= b_s2_valid_d;
        end
      end

      assign a_rdata  = a_s2_data_q;
      assign b_rdata  = b_s2_data_q;
      assign a_rvalid = a_s2_valid_q;
      assign b_rvalid = b_s2_valid_q;
    end else begin : g_lat1
      assign a_rdata  = a_s1_data_q;
      assign b_rdata  = b_s1_data_q;
      assign a_rvalid = a_s1_valid_q;
      assign b_rvalid = b_s1_valid_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dpram_be_init.sv
`default_nettype none
// ============================================================================
// tb_dpram_be_init : scoreboard bench driving a write-first/lat-1 and a
// read-first/lat-2 instance with identical stimulus.  Revision 1.0
// ============================================================================
module tb_dpram_be_init;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic init_req = 1'b0;
  logic a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
  logic [3:0]    a_be = '0, b_be = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;

  logic          r0_ready, r0_a_rvalid, r0_b_rvalid;
  logic [DW-1:0] r0_a_rdata, r0_b_rdata;
  logic          r1_ready, r1_a_rvalid, r1_b_rvalid;
  logic [DW-1:0] r1_a_rdata, r1_b_rdata;

  always #5 clk = ~clk;

  dpram_be_init #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .COLL_MODE(0), .INIT_VAL(32'h0)) dut0 (
    .clk(clk), .reset(reset), .init_req(init_req), .ready(r0_ready),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(r0_a_rdata), .a_rvalid(r0_a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(r0_b_rdata), .b_rvalid(r0_b_rvalid)
  );

  dpram_be_init #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .COLL_MODE(1), .INIT_VAL(32'h0)) dut1 (
    .clk(clk), .reset(reset), .init_req(init_req), .ready(r1_ready),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(r1_a_rdata), .a_rvalid(r1_a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(r1_b_rdata), .b_rvalid(r1_b_rvalid)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t q_a0[$], q_b0[$], q_a1[$], q_b1[$];
  logic [DW-1:0] last_a0 = '0, last_b0 = '0, last_a1 = '0, last_b1 = '0;
  logic [DW-1:0] mem_m [16];
  bit m_ready = 1'b0;
  int m_cnt = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  function automatic void chk(input string tag, input logic rv, input logic [DW-1:0] rd,
                              input bit ev, input logic [DW-1:0] ed);
    total++;
    assert (rv === ev) else begin
      bad++;
      $error("FAIL %s_rvalid cyc=%0d got=%0b exp=%0b", tag, cyc, rv, ev);
    end
    total++;
    assert (rd === ed) else begin
      bad++;
      $error("FAIL %s_rdata cyc=%0d got=%h exp=%h", tag, cyc, rd, ed);
    end
  endfunction

  function automatic void chk_rdy(input string tag, input logic got);
    total++;
    assert (got === m_ready) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0b exp=%0b", tag, cyc, got, m_ready);
    end
  endfunction

  task automatic check_all();
    bit ev;
    logic [DW-1:0] ed;
    chk_rdy("ready0", r0_ready);
    chk_rdy("ready1", r1_ready);
    ev = (q_a0.size() > 0) && (q_a0[0].due == cyc);
    ed = ev ? q_a0[0].d : last_a0;
    chk("a0", r0_a_rvalid, r0_a_rdata, ev, ed);
    if (ev) begin last_a0 = ed; void'(q_a0.pop_front()); end
    ev = (q_b0.size() > 0) && (q_b0[0].due == cyc);
    ed = ev ? q_b0[0].d : last_b0;
    chk("b0", r0_b_rvalid, r0_b_rdata, ev, ed);
    if (ev) begin last_b0 = ed; void'(q_b0.pop_front()); end
    ev = (q_a1.size() > 0) && (q_a1[0].due == cyc);
    ed = ev ? q_a1[0].d : last_a1;
    chk("a1", r1_a_rvalid, r1_a_rdata, ev, ed);
    if (ev) begin last_a1 = ed; void'(q_a1.pop_front()); end
    ev = (q_b1.size() > 0) && (q_b1[0].due == cyc);
    ed = ev ? q_b1[0].d : last_b1;
    chk("b1", r1_b_rvalid, r1_b_rdata, ev, ed);
    if (ev) begin last_b1 = ed; void'(q_b1.pop_front()); end
  endtask

  // One clock: predict the edge from the current inputs, clock, then check.
  task automatic step();
    logic [DW-1:0] oa, ob, na, nb;
    if (m_ready) begin
      oa = mem_m[a_addr];
      ob = mem_m[b_addr];
      for (int i = 0; i < 4; i++)
        if (b_en && b_we && b_be[i]) mem_m[b_addr][i*8 +: 8] = b_wdata[i*8 +: 8];
      for (int i = 0; i < 4; i++)
        if (a_en && a_we && a_be[i]) mem_m[a_addr][i*8 +: 8] = a_wdata[i*8 +: 8];
      na = mem_m[a_addr];
      nb = mem_m[b_addr];
      if (a_en) begin
        q_a0.push_back(exp_t'{na, cyc + 1});
        q_a1.push_back(exp_t'{oa, cyc + 2});
      end
      if (b_en) begin
        q_b0.push_back(exp_t'{nb, cyc + 1});
        q_b1.push_back(exp_t'{ob, cyc + 2});
      end
      if (init_req) begin
        m_ready = 1'b0;
        m_cnt   = 0;
      end
    end else begin
      mem_m[m_cnt] = '0;
      if (m_cnt == 15) begin
        m_ready = 1'b1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic set_a(input logic en, input logic we, input logic [3:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_en = en; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [3:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_en = en; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
  endtask

  task automatic idle(input int n);
    set_a(1'b0, 1'b0, 4'h0, '0, '0);
    set_b(1'b0, 1'b0, 4'h0, '0, '0);
    init_req = 1'b0;
    repeat (n) step();
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b0, 4'h0, AW'(i), '0);
      set_b(1'b1, 1'b0, 4'h0, AW'(15 - i), '0);
      step();
    end
    idle(3);
  endtask

  // Anything in flight is discarded: scoreboard and held rdata go back to zero.
  task automatic do_reset(input int n);
    reset = 1'b1;
    set_a(1'b0, 1'b0, 4'h0, '0, '0);
    set_b(1'b0, 1'b0, 4'h0, '0, '0);
    init_req = 1'b0;
    q_a0.delete(); q_b0.delete(); q_a1.delete(); q_b1.delete();
    last_a0 = '0; last_b0 = '0; last_a1 = '0; last_b1 = '0;
    m_ready = 1'b0;
    m_cnt   = 0;
    #1;
    check_all();
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      check_all();
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    #2;
    do_reset(3);

    // Accesses presented during INIT must be ignored.
    set_a(1'b1, 1'b1, 4'hF, 4'd2, 32'hDEADBEEF);
    set_b(1'b1, 1'b0, 4'h0, 4'd9, '0);
    repeat (16) step();
    idle(1);
    read_all();

    // Byte-lane write then readback.
    set_a(1'b1, 1'b1, 4'b0101, 4'd3, 32'hAABBCCDD); step();
    set_a(1'b1, 1'b0, 4'h0, 4'd3, '0); step();
    // be=0 write leaves memory alone but still returns data.
    set_a(1'b1, 1'b1, 4'h0, 4'd3, 32'hFFFFFFFF); step();
    idle(3);

    // Cross-port collision at address 5.
    set_a(1'b1, 1'b1, 4'hF, 4'd5, 32'h11111111); step();
    set_a(1'b1, 1'b0, 4'h0, 4'd5, '0);
    set_b(1'b1, 1'b1, 4'hF, 4'd5, 32'h22222222); step();
    idle(3);

    // Write-write collision at address 7.
    set_a(1'b1, 1'b1, 4'b1100, 4'd7, 32'h01020304);
    set_b(1'b1, 1'b1, 4'b0110, 4'd7, 32'h0A0B0C0D); step();
    set_a(1'b1, 1'b0, 4'h0, 4'd7, '0);
    set_b(1'b1, 1'b0, 4'h0, 4'd7, '0); step();
    idle(3);

    // Back-to-back reads.
    set_a(1'b1, 1'b0, 4'h0, 4'd3, '0); step();
    set_a(1'b1, 1'b0, 4'h0, 4'd5, '0); step();
    set_a(1'b1, 1'b0, 4'h0, 4'd7, '0); step();
    set_a(1'b1, 1'b0, 4'h0, 4'd0, '0); step();
    idle(3);

    // Mixed traffic on a narrow address window to provoke collisions.
    for (int k = 0; k < 60; k++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            AW'($urandom_range(0, 3)), $urandom);
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            AW'($urandom_range(0, 3)), $urandom);
      step();
    end
    idle(3);

    // init_req with a read issued in the same cycle.
    set_a(1'b1, 1'b0, 4'h0, 4'd7, '0);
    init_req = 1'b1;
    step();
    idle(18);
    read_all();

    // Reset with a read still in the lat-2 pipeline.
    set_a(1'b1, 1'b0, 4'h0, 4'd1, '0);
    set_b(1'b1, 1'b0, 4'h0, 4'd2, '0);
    step();
    do_reset(2);
    idle(17);

    // Dirty memory, re-init, then reset at INIT cycle 8.
    set_a(1'b1, 1'b1, 4'hF, 4'd12, 32'hCAFEF00D);
    set_b(1'b1, 1'b1, 4'hF, 4'd4, 32'h5A5A5A5A); step();
    init_req = 1'b1;
    set_a(1'b0, 1'b0, 4'h0, '0, '0);
    set_b(1'b0, 1'b0, 4'h0, '0, '0);
    step();
    idle(8);
    do_reset(2);
    idle(17);
    read_all();

    total++;
    assert (q_a0.size() + q_b0.size() + q_a1.size() + q_b1.size() == 0) else begin
      bad++;
      $error("FAIL drain pending=%0d exp=0", q_a0.size() + q_b0.size() + q_a1.size() + q_b1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
